// File: rtl/apb4_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb4_master_bridge
//  Description : APB4 requester that turns a valid/ready command into APB setup/access
//                transfers, with one-hot slave decode and a valid/ready response.
//                Optional ACCESS-phase timeout is built when APB_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb4_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 28,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     paddr,
    output logic [NUM_SLAVES-1:0] pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    output logic [2:0]            pprot,
    input  logic                  pready,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = (NUM_SLAVES <= 1) ? 1 : $clog2(NUM_SLAVES);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) || NUM_SLAVES < 1 ||
        NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("apb4_master_bridge: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [2:0]          pprot_q, pprot_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic [SEL_W-1:0]    w_idx;
    logic                w_hit;
    logic                w_fire;

`ifdef APB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
`endif

    assign w_idx  = cmd_addr[SEL_LSB +: SEL_W];
    assign w_hit  = int'(w_idx) < NUM_SLAVES;
    assign w_fire = cmd_valid && cmd_ready;

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        idx_d         = idx_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
`ifdef APB_TIMEOUT_EN
        tcnt_d        = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_fire) begin
                    paddr_d       = cmd_addr;
                    pwrite_d      = cmd_write;
                    pwdata_d      = cmd_wdata;
                    pprot_d       = cmd_prot;
                    idx_d         = w_idx;
                    rsp_timeout_d = 1'b0;
                    if (w_hit) begin
                        pstrb_d = cmd_write ? cmd_strb : '0;
                        state_d = SETUP;
`ifdef APB_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end else begin
                        // Decode miss: answer straight away, never touch the bus
                        pstrb_d     = '0;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    pstrb_d       = '0;
                    state_d       = RESP;
`ifdef APB_TIMEOUT_EN
                end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    pstrb_d       = '0;
                    state_d       = RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
`endif
                end
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            idx_q         <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tcnt_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            idx_q         <= idx_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
`ifdef APB_TIMEOUT_EN
            tcnt_q        <= tcnt_d;
`endif
        end
    end

    always_comb begin
        pselx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            pselx[i] = ((state_q == SETUP) || (state_q == ACCESS)) && (int'(idx_q) == i);
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !preset;
    assign penable     = (state_q == ACCESS);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb4_master_bridge
//  Description : Directed self-checking bench for apb4_master_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_master_bridge;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_valid3, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_ready, pready, pslverr;
    logic [31:0] prdata;

    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, penable, pwrite;
    logic [31:0] rsp_rdata, paddr, pwdata;
    logic [3:0]  pselx, pstrb;
    logic [2:0]  pprot;

    logic        cmd_ready3, rsp_valid3, rsp_err3, rsp_timeout3, penable3, pwrite3;
    logic [31:0] rsp_rdata3, paddr3, pwdata3;
    logic [2:0]  pselx3;
    logic [3:0]  pstrb3;
    logic [2:0]  pprot3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    apb4_master_bridge #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) u_dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    apb4_master_bridge #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(16)) u_dut3 (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
        .rsp_err(rsp_err3), .rsp_timeout(rsp_timeout3),
        .paddr(paddr3), .pselx(pselx3), .penable(penable3), .pwrite(pwrite3),
        .pwdata(pwdata3), .pstrb(pstrb3), .pprot(pprot3),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
        rsp_ready = 1'b1; pready = 1'b0; pslverr = 1'b0; prdata = '0;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_outputs", {rsp_valid, rsp_err, rsp_timeout, pselx, penable, pwrite, pstrb, pprot}, 0);
        check("rst_data", {paddr, pwdata, rsp_rdata}, 0);
        preset = 1'b0;
        #1;
        check("rst_release_ready", cmd_ready, 1);

        // Test 1: zero-wait write to slave 1, pready high already in SETUP
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1000_0010;
        cmd_wdata = 32'hDEAD_BEEF; cmd_strb = 4'hF; cmd_prot = 3'b101; pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t1_setup_psel", {pselx, penable}, {4'b0010, 1'b0});
        check("t1_setup_bus", {paddr, pwdata, pstrb, pprot, pwrite}, {32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 3'b101, 1'b1});
        check("t1_setup_ready", {cmd_ready, rsp_valid}, 2'b00);
        tick();
        check("t1_access", {pselx, penable, rsp_valid}, {4'b0010, 1'b1, 1'b0});
        tick();
        check("t1_resp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
        check("t1_resp_bus", {pselx, penable, pstrb, cmd_ready}, 0);
        tick();
        check("t1_idle", {cmd_ready, rsp_valid}, 2'b10);
        check("t1_held_addr", {paddr, pwdata, pprot}, {32'h1000_0010, 32'hDEAD_BEEF, 3'b101});

        // Test 2: read to slave 0 with three wait states
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040; cmd_strb = 4'hF;
        cmd_prot = 3'b000; pready = 1'b0; prdata = 32'h1234_5678;
        for (int c = 1; c <= 6; c++) begin
            tick();
            cmd_valid = 1'b0;
            check($sformatf("t2_psel_c%0d", c), pselx, (c <= 5) ? 4'b0001 : 4'b0000);
            check($sformatf("t2_pen_c%0d", c), penable, (c >= 2 && c <= 5));
            check($sformatf("t2_rv_c%0d", c), rsp_valid, (c == 6));
            check($sformatf("t2_pstrb_c%0d", c), pstrb, 0);
            if (c == 5) pready = 1'b1;
        end
        check("t2_rdata", {rsp_err, rsp_rdata}, {1'b0, 32'h1234_5678});
        check("t2_pwrite", pwrite, 0);
        tick();

        // Test 3: write with slave error, response back-pressured
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h2000_0004; cmd_wdata = 32'h0000_00A5;
        cmd_strb = 4'h3; pready = 1'b1; pslverr = 1'b1; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("t3_setup", {pselx, pstrb}, {4'b0100, 4'h3});
        tick();
        tick();
        pslverr = 1'b0;
        check("t3_resp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {1'b1, 1'b1, 1'b0, 32'h0});
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("t3_hold_c%0d", c), {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready, pselx},
                  {1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0000});
        end
        rsp_ready = 1'b1;
        tick();
        check("t3_release", {cmd_ready, rsp_valid}, 2'b10);

        // Test 4: decode miss on the three-slave instance
        cmd_valid3 = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3000_0000; prdata = 32'hFFFF_FFFF;
        #1;
        check("t4_ready", cmd_ready3, 1);
        tick();
        cmd_valid3 = 1'b0;
        check("t4_resp", {rsp_valid3, rsp_err3, rsp_timeout3, rsp_rdata3}, {1'b1, 1'b1, 1'b0, 32'h0});
        check("t4_bus", {pselx3, penable3}, 0);
        tick();
        check("t4_idle", {cmd_ready3, rsp_valid3, pselx3}, {1'b1, 1'b0, 3'b000});

        // Test 5: slave never ready
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0000; cmd_strb = 4'hF; pready = 1'b0;
`ifdef APB_TIMEOUT_EN
        for (int c = 1; c <= 18; c++) begin
            tick();
            cmd_valid = 1'b0;
            check($sformatf("t5_psel_c%0d", c), pselx, (c <= 17) ? 4'b0001 : 4'b0000);
        end
        check("t5_resp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, penable}, {1'b1, 1'b1, 1'b1, 32'h0, 1'b0});
        tick();
        check("t5_idle", cmd_ready, 1);
`else
        tick();
        cmd_valid = 1'b0;
        repeat (1000) tick();
        check("t5_stuck", {pselx, penable, rsp_valid, rsp_timeout}, {4'b0001, 1'b1, 1'b0, 1'b0});
        preset = 1'b1;
        tick();
        preset = 1'b0;
        #1;
        check("t5_recover", {cmd_ready, pselx}, {1'b1, 4'b0000});
`endif

        // Test 6: reset pulsed mid-ACCESS, then a normal read
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1000_0000; pready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t6_access", {pselx, penable}, {4'b0010, 1'b1});
        preset = 1'b1;
        #1;
        check("t6_ready_in_rst", cmd_ready, 0);
        tick();
        check("t6_reset", {pselx, penable, rsp_valid, cmd_ready}, 0);
        preset = 1'b0;
        #1;
        check("t6_ready_after", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = 32'h1000_0008; prdata = 32'hCAFE_F00D; pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("t6_read", {rsp_valid, rsp_err, rsp_rdata, pselx}, {1'b1, 1'b0, 32'hCAFE_F00D, 4'b0000});
        tick();
        check("t6_idle", {cmd_ready, rsp_valid}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
